// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one trans_fsm UART transmitter among NUM_REQ clients.
// Optional build macro UART_ARB_FIXED_PRIO_EN adds a fixed_prio input selecting lowest-index-first arbitration.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 10,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned TW      = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
`ifdef UART_ARB_FIXED_PRIO_EN
    input  logic                  fixed_prio,
`endif
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic                  err_timeout,
    output logic                  tx_enable,
    output logic                  tx_send,
    output logic [DW-1:0]         tx_datain,
    input  logic                  tx_busy,
    output logic [2:0]            cur_owner,
    output logic                  active
);

    localparam int unsigned IW     = 3;
    localparam int unsigned PW     = IW + 1;
    localparam int unsigned MAXREQ = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_FALL,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       rr_ptr, rr_nxt;
    logic [TW-1:0]       wd_cnt, wd_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt, done_nxt;
    logic                err_nxt, send_nxt, active_nxt;
    logic [DW-1:0]       datain_nxt;
    logic [IW-1:0]       owner_nxt;

    logic [MAXREQ-1:0]   req_pad;
    logic [DW-1:0]       data_arr [MAXREQ];
    logic [IW-1:0]       base, win;
    logic                found;
    logic [PW-1:0]       probe;
    logic [PW-1:0]       owner_inc;
    logic [IW-1:0]       rr_wrap;
    logic [NUM_REQ-1:0]  win_oh, owner_oh;
    logic                wd_expired;

    // Pad requests and frames to 8 slots so a 3-bit index always selects in range
    assign req_pad = MAXREQ'(req);

    always_comb begin
        for (int i = 0; i < int'(MAXREQ); i++) begin
            data_arr[i] = '0;
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            data_arr[i] = req_data[i*DW +: DW];
        end
    end

    // Search starts at the round-robin pointer, or at client 0 when fixed priority is selected
    always_comb begin
`ifdef UART_ARB_FIXED_PRIO_EN
        base = fixed_prio ? '0 : rr_ptr;
`else
        base = rr_ptr;
`endif
        win   = '0;
        found = 1'b0;
        probe = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            probe = PW'(base) + PW'(i);
            if (probe >= PW'(NUM_REQ)) begin
                probe = probe - PW'(NUM_REQ);
            end
            if (!found && req_pad[probe[IW-1:0]]) begin
                found = 1'b1;
                win   = probe[IW-1:0];
            end
        end
    end

    assign win_oh     = NUM_REQ'(1) << win;
    assign owner_oh   = NUM_REQ'(1) << cur_owner;
    assign owner_inc  = PW'(cur_owner) + PW'(1);
    assign rr_wrap    = (owner_inc >= PW'(NUM_REQ)) ? '0 : owner_inc[IW-1:0];
    assign wd_expired = (wd_cnt == TW'(TIMEOUT));

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        rr_nxt     = rr_ptr;
        wd_nxt     = wd_cnt;
        gnt_nxt    = '0;
        done_nxt   = '0;
        err_nxt    = 1'b0;
        send_nxt   = tx_send;
        datain_nxt = tx_datain;
        owner_nxt  = cur_owner;
        active_nxt = active;

        case (state)
            IDLE: begin
                send_nxt = 1'b0;
                if (enable && found) begin
                    state_nxt  = SEND;
                    gnt_nxt    = win_oh;
                    datain_nxt = data_arr[win];
                    send_nxt   = 1'b1;
                    owner_nxt  = win;
                    active_nxt = 1'b1;
                    wd_nxt     = '0;
                end
            end
            SEND: begin
                if (tx_busy) begin
                    send_nxt  = 1'b0;
                    state_nxt = WAIT_FALL;
                    wd_nxt    = '0;
                end else if (wd_expired) begin
                    send_nxt  = 1'b0;
                    state_nxt = DONE;
                    done_nxt  = owner_oh;
                    err_nxt   = 1'b1;
                end else begin
                    wd_nxt = wd_cnt + TW'(1);
                end
            end
            WAIT_FALL: begin
                if (!tx_busy) begin
                    state_nxt = DONE;
                    done_nxt  = owner_oh;
                end else if (wd_expired) begin
                    state_nxt = DONE;
                    done_nxt  = owner_oh;
                    err_nxt   = 1'b1;
                end else begin
                    wd_nxt = wd_cnt + TW'(1);
                end
            end
            DONE: begin
                rr_nxt     = rr_wrap;
                active_nxt = 1'b0;
                send_nxt   = 1'b0;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt  = IDLE;
                send_nxt   = 1'b0;
                active_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            wd_cnt      <= '0;
            gnt         <= '0;
            done        <= '0;
            err_timeout <= 1'b0;
            tx_send     <= 1'b0;
            tx_datain   <= '0;
            cur_owner   <= '0;
            active      <= 1'b0;
            tx_enable   <= 1'b1;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_nxt;
            wd_cnt      <= wd_nxt;
            gnt         <= gnt_nxt;
            done        <= done_nxt;
            err_timeout <= err_nxt;
            tx_send     <= send_nxt;
            tx_datain   <= datain_nxt;
            cur_owner   <= owner_nxt;
            active      <= active_nxt;
            tx_enable   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter with a simple trans_fsm busy model.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DW      = 10;
    localparam int unsigned TIMEOUT = 200;
    localparam int unsigned TW      = 8;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  enable;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    done;
    logic                  err_timeout;
    logic                  tx_enable;
    logic                  tx_send;
    logic [DW-1:0]         tx_datain;
    logic                  tx_busy = 1'b0;
    logic [2:0]            cur_owner;
    logic                  active;
`ifdef UART_ARB_FIXED_PRIO_EN
    logic                  fixed_prio;
`endif

    int errors = 0;
    int checks = 0;
    int bfm_hold = 120;
    bit bfm_respond = 1'b1;
    int bfm_phase = 0;
    int bfm_cnt = 0;

    localparam logic [24:0] RESET_VEC = {4'b0, 4'b0, 1'b0, 1'b0, 10'h0, 3'd0, 1'b0, 1'b1};

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DW(DW),
        .TIMEOUT(TIMEOUT),
        .TW(TW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
`ifdef UART_ARB_FIXED_PRIO_EN
        .fixed_prio(fixed_prio),
`endif
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .done(done),
        .err_timeout(err_timeout),
        .tx_enable(tx_enable),
        .tx_send(tx_send),
        .tx_datain(tx_datain),
        .tx_busy(tx_busy),
        .cur_owner(cur_owner),
        .active(active)
    );

    always #5 clock = ~clock;

    // Transmitter model: busy rises 3 cycles after send is seen and stays high bfm_hold cycles
    always begin
        @(posedge clock);
        #2;
        if (!reset) begin
            bfm_phase = 0;
            bfm_cnt   = 0;
            tx_busy   = 1'b0;
        end else begin
            case (bfm_phase)
                0: if (tx_send && bfm_respond) begin
                    bfm_phase = 1;
                    bfm_cnt   = 0;
                end
                1: begin
                    bfm_cnt++;
                    if (bfm_cnt == 3) begin
                        tx_busy   = 1'b1;
                        bfm_phase = 2;
                        bfm_cnt   = 0;
                    end
                end
                2: begin
                    bfm_cnt++;
                    if (bfm_cnt == bfm_hold) begin
                        tx_busy   = 1'b0;
                        bfm_phase = 0;
                    end
                end
                default: bfm_phase = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance until a done pulse; returns its cycle offset and what was seen before it
    task automatic wait_done(input int limit, output int cyc, output int sends, output int gnts);
        cyc   = 0;
        sends = 0;
        gnts  = 0;
        while (done == '0 && cyc <= limit) begin
            tick();
            cyc++;
            if (done == '0) begin
                if (tx_send) sends++;
                if (gnt != '0) gnts++;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        enable   = 1'b1;
        req      = '0;
        req_data = '0;
        repeat (3) tick();
        checks++;
        if ({gnt, done, err_timeout, tx_send, tx_datain, cur_owner, active, tx_enable} !== RESET_VEC)
            begin errors++; $display("FAIL reset_outputs: got %h want %h",
                {gnt, done, err_timeout, tx_send, tx_datain, cur_owner, active, tx_enable}, RESET_VEC); end
        reset = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0000 || active !== 1'b0)
            begin errors++; $display("FAIL idle_after_reset: gnt=%b active=%b want 0000/0", gnt, active); end
    endtask

    task automatic test_single();
        int cyc, sends, gnts;
        bfm_hold = 120;
        req_data[1*DW +: DW] = 10'h2A5;
        req = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt: got %b want 0010", gnt); end
        checks++;
        if (tx_send !== 1'b1 || tx_datain !== 10'h2A5)
            begin errors++; $display("FAIL single_send: send=%b data=%h want 1/2a5", tx_send, tx_datain); end
        checks++;
        if (cur_owner !== 3'd1 || active !== 1'b1)
            begin errors++; $display("FAIL single_owner: owner=%0d active=%b want 1/1", cur_owner, active); end
        req = '0;
        req_data = '0;
        wait_done(300, cyc, sends, gnts);
        checks++;
        if (cyc !== 124) begin errors++; $display("FAIL single_done_latency: got %0d want 124", cyc); end
        checks++;
        if (sends !== 3) begin errors++; $display("FAIL single_send_len: got %0d want 3", sends); end
        checks++;
        if (done !== 4'b0010 || err_timeout !== 1'b0 || gnts !== 0)
            begin errors++; $display("FAIL single_done: done=%b err=%b gnts=%0d want 0010/0/0", done, err_timeout, gnts); end
        checks++;
        if (tx_datain !== 10'h2A5) begin errors++; $display("FAIL single_capture: got %h want 2a5", tx_datain); end
        tick();
        checks++;
        if (done !== 4'b0000 || active !== 1'b0 || dut.rr_ptr !== 3'd2)
            begin errors++; $display("FAIL single_after: done=%b active=%b rr=%0d want 0000/0/2", done, active, dut.rr_ptr); end
    endtask

    task automatic test_timeout();
        int cyc, sends, gnts;
        bfm_respond = 1'b0;
        req_data[2*DW +: DW] = 10'h1C3;
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100) begin errors++; $display("FAIL timeout_gnt: got %b want 0100", gnt); end
        req = '0;
        wait_done(TIMEOUT + 50, cyc, sends, gnts);
        checks++;
        if (cyc !== int'(TIMEOUT) + 1) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", cyc, TIMEOUT + 1); end
        checks++;
        if (sends !== int'(TIMEOUT)) begin errors++; $display("FAIL timeout_send_len: got %0d want %0d", sends, TIMEOUT); end
        checks++;
        if (done !== 4'b0100 || err_timeout !== 1'b1 || tx_send !== 1'b0)
            begin errors++; $display("FAIL timeout_done: done=%b err=%b send=%b want 0100/1/0", done, err_timeout, tx_send); end
        bfm_respond = 1'b1;
        tick();
        checks++;
        if (err_timeout !== 1'b0 || done !== 4'b0000 || active !== 1'b0)
            begin errors++; $display("FAIL timeout_pulse: err=%b done=%b active=%b want 0/0000/0", err_timeout, done, active); end
        req_data[0 +: DW] = 10'h05A;
        req = 4'b0001;
        tick();
        checks++;
        if (gnt !== 4'b0001 || tx_datain !== 10'h05A)
            begin errors++; $display("FAIL timeout_next_gnt: gnt=%b data=%h want 0001/05a", gnt, tx_datain); end
        req = '0;
        wait_done(300, cyc, sends, gnts);
        checks++;
        if (done !== 4'b0001 || err_timeout !== 1'b0 || cyc !== 124)
            begin errors++; $display("FAIL timeout_next_done: done=%b err=%b cyc=%0d want 0001/0/124", done, err_timeout, cyc); end
        tick();
    endtask

    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int n_gnt = 0;
        int n_done = 0;
        int cyc = 0;
        bit outstanding = 1'b0;
        logic [NUM_REQ-1:0] last_gnt = '0;
        logic [NUM_REQ-1:0] exp_gnt;
        logic [DW-1:0] exp_data;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bfm_hold = 5;
        for (int i = 0; i < int'(NUM_REQ); i++) req_data[i*DW +: DW] = DW'(10'h300 + i);
        req = 4'b1111;
        while (n_done < 5 && cyc < 300) begin
            tick();
            cyc++;
            if (gnt != '0) begin
                exp_gnt  = (n_gnt < 5) ? (NUM_REQ'(1) << exp_order[n_gnt]) : '0;
                exp_data = (n_gnt < 5) ? DW'(10'h300 + exp_order[n_gnt]) : '0;
                checks++;
                if (gnt !== exp_gnt || outstanding)
                    begin errors++; $display("FAIL rr_gnt%0d: got %b want %b overlap=%b", n_gnt, gnt, exp_gnt, outstanding); end
                checks++;
                if (tx_datain !== exp_data)
                    begin errors++; $display("FAIL rr_data%0d: got %h want %h", n_gnt, tx_datain, exp_data); end
                outstanding = 1'b1;
                last_gnt = gnt;
                n_gnt++;
            end
            if (done != '0) begin
                checks++;
                if (done !== last_gnt || !outstanding)
                    begin errors++; $display("FAIL rr_done%0d: got %b want %b", n_done, done, last_gnt); end
                outstanding = 1'b0;
                n_done++;
            end
        end
        req = '0;
        checks++;
        if (n_gnt !== 5 || n_done !== 5)
            begin errors++; $display("FAIL rr_counts: gnts=%0d dones=%0d want 5/5", n_gnt, n_done); end
        repeat (2) tick();
    endtask

    task automatic test_reset_midframe();
        int cyc, sends, gnts;
        int n_ev = 0;
        int waited = 0;
        bfm_hold = 120;
        req_data[2*DW +: DW] = 10'h0AA;
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100) begin errors++; $display("FAIL midrst_gnt: got %b want 0100", gnt); end
        req = '0;
        while (!(active && !tx_send && tx_busy) && waited < 20) begin tick(); waited++; end
        checks++;
        if (waited >= 20) begin errors++; $display("FAIL midrst_wait_fall: waited %0d want <20", waited); end
        repeat (2) tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({gnt, done, err_timeout, tx_send, tx_datain, cur_owner, active, tx_enable} !== RESET_VEC)
            begin errors++; $display("FAIL midrst_outputs: got %h want %h",
                {gnt, done, err_timeout, tx_send, tx_datain, cur_owner, active, tx_enable}, RESET_VEC); end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (done != '0 || gnt != '0) n_ev++;
        end
        checks++;
        if (n_ev !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d events want 0", n_ev); end
        bfm_hold = 5;
        req_data[0 +: DW] = 10'h111;
        req = 4'b1101;
        tick();
        checks++;
        if (gnt !== 4'b0001 || cur_owner !== 3'd0 || tx_datain !== 10'h111)
            begin errors++; $display("FAIL midrst_next_gnt: gnt=%b owner=%0d data=%h want 0001/0/111", gnt, cur_owner, tx_datain); end
        req = '0;
        wait_done(50, cyc, sends, gnts);
        checks++;
        if (done !== 4'b0001) begin errors++; $display("FAIL midrst_next_done: got %b want 0001", done); end
        tick();
    endtask

    task automatic test_enable();
        int cyc, sends, gnts;
        int n_gnt = 0;
        enable = 1'b0;
        req_data[3*DW +: DW] = 10'h155;
        req = 4'b1000;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (gnt != '0 || active) n_gnt++;
        end
        checks++;
        if (n_gnt !== 0) begin errors++; $display("FAIL enable_block: got %0d grant cycles want 0", n_gnt); end
        enable = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b1000 || tx_datain !== 10'h155)
            begin errors++; $display("FAIL enable_gnt: gnt=%b data=%h want 1000/155", gnt, tx_datain); end
        req = '0;
        enable = 1'b0;
        bfm_hold = 20;
        wait_done(100, cyc, sends, gnts);
        checks++;
        if (done !== 4'b1000 || cyc !== 24 || tx_enable !== 1'b1)
            begin errors++; $display("FAIL enable_inflight_done: done=%b cyc=%0d txen=%b want 1000/24/1", done, cyc, tx_enable); end
        enable = 1'b1;
        repeat (2) tick();
    endtask

`ifdef UART_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        int n_gnt = 0;
        int cyc = 0;
        bfm_hold = 5;
        fixed_prio = 1'b1;
        req = 4'b1011;
        while (n_gnt < 3 && cyc < 200) begin
            tick();
            cyc++;
            if (gnt != '0) begin
                checks++;
                if (gnt !== 4'b0001) begin errors++; $display("FAIL fixed_gnt%0d: got %b want 0001", n_gnt, gnt); end
                n_gnt++;
            end
        end
        checks++;
        if (n_gnt !== 3) begin errors++; $display("FAIL fixed_count: got %0d want 3", n_gnt); end
        req = '0;
        repeat (40) tick();
        fixed_prio = 1'b0;
    endtask
`endif

    initial begin
`ifdef UART_ARB_FIXED_PRIO_EN
        fixed_prio = 1'b0;
`endif
        test_reset();
        test_single();
        test_timeout();
        test_round_robin();
        test_reset_midframe();
        test_enable();
`ifdef UART_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one trans_fsm UART transmitter between NUM_REQ client requesters.
- Arbitrates among them round-robin, latches the winner's 10-bit frame and drives the transmitter's send/datain.
- Tracks transmitter busy to detect completion and returns per-client grant and done pulses.
- Sits between client logic and trans_fsm on the system clock domain; includes a watchdog so a stalled transmitter cannot lock the arbiter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DW, 10, frame width; matches trans_fsm datain
- TIMEOUT, 1023, watchdog limit in clock cycles, applied per wait state
- TW, 10, watchdog counter width; must satisfy 2^TW > TIMEOUT

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  arbitration enable
- req  input  NUM_REQ  per-client send request, level
- req_data  input  NUM_REQ*DW  client frames; client i occupies [i*DW +: DW]
- gnt  output  NUM_REQ  one-hot, 1-cycle pulse: client's frame accepted
- done  output  NUM_REQ  one-hot, 1-cycle pulse: client's frame finished or aborted
- err_timeout  output  1  1-cycle pulse: watchdog expired
- tx_enable  output  1  drives trans_fsm enable
- tx_send  output  1  drives trans_fsm send
- tx_datain  output  DW  drives trans_fsm datain
- tx_busy  input  1  from trans_fsm busy
- cur_owner  output  3  index of the granted client; valid while active
- active  output  1  high from grant until done

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr_ptr=0.
  - gnt=0, done=0, err_timeout=0, tx_send=0, tx_datain=0, cur_owner=0, active=0.
  - tx_enable=1.
  - All outputs are registered.
- States: IDLE, SEND, WAIT_FALL, DONE.
- IDLE:
  - If enable=1 and req!=0, pick the first set req at or after rr_ptr, wrapping modulo NUM_REQ.
  - Next edge: state=SEND, gnt[w]=1 for one cycle, tx_datain<=req_data[w], tx_send=1, cur_owner=w, active=1.
  - Latency from req sampled to gnt/tx_send is 1 cycle.
- SEND:
  - Hold tx_send=1 and tx_datain stable until tx_busy is sampled 1; then tx_send=0 and state=WAIT_FALL.
  - The watchdog counts cycles in SEND. Reaching TIMEOUT -> DONE with err_timeout.
- WAIT_FALL:
  - On tx_busy sampled 0 -> DONE.
  - The watchdog is restarted on entry; reaching TIMEOUT -> DONE with err_timeout.
- DONE (one cycle):
  - done[cur_owner]=1; err_timeout=1 if entered by timeout.
  - rr_ptr=(cur_owner+1) mod NUM_REQ, active=0, tx_send=0, state=IDLE.
- Minimum gap between consecutive grants: DONE + IDLE = 2 cycles after the busy fall is sampled.
- Client handshake:
  - Client holds req and its data stable until it sees gnt.
  - Client deasserts req on the cycle after gnt; a req still high in IDLE is a new request.
  - Frame data is captured at grant; later changes are ignored.
  - req dropped before grant: no grant; this is legal.
- enable=0:
  - In IDLE, blocks new arbitration.
  - An in-flight transaction completes normally; tx_enable stays 1.
- Simultaneous requests: exactly one gnt bit per transaction.
- rr_ptr advances past the winner only; a starved client is served within NUM_REQ transactions.
- Reset asserted mid-transaction: immediate return to reset values; no done pulse is issued for the aborted transaction.
- tx_busy high while in IDLE: ignored; it does not block arbitration.

Optional Feature:
- Macro: UART_ARB_FIXED_PRIO_EN.
- Defined:
  - Adds input port fixed_prio (1 bit).
  - When fixed_prio=1, IDLE grants the lowest-index set req regardless of rr_ptr. rr_ptr is still updated in DONE.
  - When fixed_prio=0, behaviour is round-robin.
- Undefined:
  - Port absent; always round-robin.

Test Plan:
- Single request: req=4'b0010, data=10'h2A5; BFM raises busy 3 cycles after send and holds it 120 cycles.
  - Expect gnt=4'b0010 1 cycle after req, tx_datain=10'h2A5, tx_send high until busy is sampled.
  - Expect done=4'b0010 one cycle after busy fall, rr_ptr=2.
- All four requesting continuously from reset: grants in order 0,1,2,3,0; exactly one gnt and one done per frame; no overlapping active periods.
- Timeout: busy never rises.
  - Expect err_timeout and done[owner] after TIMEOUT+1 cycles in SEND, then return to IDLE and serve the next request.
- reset pulled low for 1 cycle during WAIT_FALL:
  - Expect all outputs at reset values, no done pulse, next grant from client 0.
- enable=0 with req=4'b1000: no gnt for 50 cycles; after enable=1, gnt=4'b1000 on the next cycle. With enable dropped mid-frame, done still fires.
- With UART_ARB_FIXED_PRIO_EN and fixed_prio=1, req=4'b1011 held: grants 0,0,0; client 1 is never granted while client 0 requests.
